fpadd_pipe: RTL

//  Parametrised, fully pipelined IEEE-754-style FP adder/subtractor with round-to-nearest-even.

---
 rtl/fp_pkg.sv | 25 ++
 rtl/fpadd_lzc.sv | 19 +
 rtl/fpadd_pipe.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared constants, field layout and helpers for the pipelined FP adder.
// Module parameters default from here so every user agrees on the format.
package fp_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam int GRS_W     = 3;

    function automatic int bias(input int exp_w);
        return (2 ** (exp_w - 1)) - 1;
    endfunction

    function automatic int exp_max(input int exp_w);
        return (2 ** exp_w) - 1;
    endfunction

    localparam int EXP_MAX = exp_max(EXP_W_DEF);

    typedef struct packed {
        logic                 sign;
        logic [EXP_W_DEF-1:0] exp;
        logic [MAN_W_DEF-1:0] man;
    } fp_t;

endpackage

// File: rtl/fpadd_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
// Zero latency, no handshake.
module fpadd_lzc #(
    parameter int W  = 28,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  vec_i,
    output logic [CW-1:0] cnt_o
);

    // Scanning upward, the highest set bit is the last to write.
    always_comb begin
        cnt_o = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (vec_i[i]) cnt_o = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fpadd_pipe.sv
// Pipelined FP add/sub with round-to-nearest-even, subnormals flushed to zero.
// Latency 4 enabled cycles, throughput 1/cycle.
// Backpressure: one enable stalls every stage when the output is held.
module fpadd_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int MW  = MAN_W + 1;
    localparam int AW  = MW + 2;
    localparam int FW  = MW + GRS_W;
    localparam int SW  = FW + 1;
    localparam int EW  = EXP_W + 2;
    localparam int LZW = $clog2(SW + 1);
    localparam logic [EW-1:0] EMAX = EW'(exp_max(EXP_W));

    typedef struct packed {
        logic             sx;
        logic             eff_sub;
        logic [EXP_W-1:0] ex;
        logic [MW-1:0]    mx;
        logic [MW-1:0]    my;
        logic [EXP_W-1:0] ediff;
    } s1_t;

    typedef struct packed {
        logic             sx;
        logic             eff_sub;
        logic [EXP_W-1:0] ex;
        logic [FW-1:0]    ax;
        logic [FW-1:0]    ay;
    } s2_t;

    typedef struct packed {
        logic             sx;
        logic             eff_sub;
        logic [EXP_W-1:0] ex;
        logic [SW-1:0]    sum;
    } s3_t;

    logic en;
    logic v1_q, v2_q, v3_q, out_valid_q;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    s3_t  s3_d, s3_q;
    logic [W-1:0] res_d, out_data_q;

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // S1: unpack, flush subnormals, order operands by magnitude
    logic             sb, za, zb, swap;
    logic [W-2:0]     mag_a, mag_b;
    logic [EXP_W-1:0] ea, eb;
    logic [MW-1:0]    ma, mb;

    always_comb begin
        sb    = in_b[W-1] ^ in_sub;
        ea    = in_a[W-2 -: EXP_W];
        eb    = in_b[W-2 -: EXP_W];
        za    = (ea == '0);
        zb    = (eb == '0);
        ma    = za ? '0 : {1'b1, in_a[MAN_W-1:0]};
        mb    = zb ? '0 : {1'b1, in_b[MAN_W-1:0]};
        mag_a = za ? '0 : in_a[W-2:0];
        mag_b = zb ? '0 : in_b[W-2:0];
        swap  = (mag_b > mag_a);

        s1_d         = '0;
        s1_d.eff_sub = in_a[W-1] ^ sb;
        s1_d.sx      = swap ? sb : in_a[W-1];
        s1_d.ex      = swap ? eb : ea;
        s1_d.mx      = swap ? mb : ma;
        s1_d.my      = swap ? ma : mb;
        s1_d.ediff   = swap ? (eb - ea) : (ea - eb);
    end

    // S2: align the smaller operand; everything shifted past R folds into sticky
    logic [2*AW-1:0] sh_wide;
    int              sh;

    always_comb begin
        sh         = (int'(s1_q.ediff) >= AW) ? AW : int'(s1_q.ediff);
        sh_wide    = {s1_q.my, 2'b00, {AW{1'b0}}} >> sh;
        s2_d       = '0;
        s2_d.sx      = s1_q.sx;
        s2_d.eff_sub = s1_q.eff_sub;
        s2_d.ex      = s1_q.ex;
        s2_d.ax      = {s1_q.mx, {GRS_W{1'b0}}};
        s2_d.ay      = {sh_wide[2*AW-1:AW], |sh_wide[AW-1:0]};
    end

    // S3: magnitude add/sub; X >= Y so the difference never goes negative
    always_comb begin
        s3_d         = '0;
        s3_d.sx      = s2_q.sx;
        s3_d.eff_sub = s2_q.eff_sub;
        s3_d.ex      = s2_q.ex;
        s3_d.sum     = s2_q.eff_sub ? ({1'b0, s2_q.ax} - {1'b0, s2_q.ay})
                                    : ({1'b0, s2_q.ax} + {1'b0, s2_q.ay});
    end

    // S4: normalise, round, classify
    logic [LZW-1:0]   lz, shl;
    logic [SW-1:0]    sh_sum;
    logic [FW-1:0]    norm;
    logic [EW-1:0]    e_n, e_f;
    logic [MW:0]      mr;
    logic [MAN_W-1:0] man_f;
    logic             rnd_up;

    fpadd_lzc #(.W(SW), .CW(LZW)) u_lzc (
        .vec_i (s3_q.sum),
        .cnt_o (lz)
    );

    always_comb begin
        shl    = lz - LZW'(1);
        sh_sum = s3_q.sum << shl;
        if (s3_q.sum[SW-1]) begin
            norm = {s3_q.sum[SW-1:2], s3_q.sum[1] | s3_q.sum[0]};
            e_n  = {2'b00, s3_q.ex} + EW'(1);
        end else begin
            norm = sh_sum[FW-1:0];
            e_n  = {2'b00, s3_q.ex} - EW'(shl);
        end
        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mr     = {1'b0, norm[FW-1:GRS_W]} + (MW+1)'(rnd_up);
        man_f  = mr[MW] ? mr[MAN_W:1] : mr[MAN_W-1:0];
        e_f    = e_n + EW'(mr[MW]);

        // A zero sum can only keep a negative sign when both inputs were -0
        if (s3_q.sum == '0)
            res_d = {s3_q.sx & !s3_q.eff_sub, {(W-1){1'b0}}};
        else if (!e_f[EW-1] && (e_f >= EMAX))
            res_d = {s3_q.sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (e_f[EW-1] || (e_f == '0))
            res_d = {s3_q.sx, {(W-1){1'b0}}};
        else
            res_d = {s3_q.sx, e_f[EXP_W-1:0], man_f};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            out_data_q  <= '0;
        end else if (en) begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            v3_q        <= v2_q;
            out_valid_q <= v3_q;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            out_data_q  <= res_d;
        end
    end

endmodule
